// File: rtl/alu_shift_pipe.sv
// alu_shift_pipe: two-stage execute unit. A barrel shifter feeds a 16-op
// ARM-style ALU. The unit keeps an architectural NZCV flag register that
// also has an external load port. Operations move through a valid/ready
// pipeline, and both stages stall together under back-pressure.
// Optional feature: define ALU_SHIFT_PIPE_RRX_EN to turn ROR #0 into RRX.
module alu_shift_pipe #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_a,
  input  logic [DATA_W-1:0] in_shift_data,
  input  logic [7:0]        in_shift_num,
  input  logic [1:0]        in_shift_op,
  input  logic [3:0]        in_alu_op,
  input  logic              in_s,
  input  logic              flag_wr,
  input  logic [3:0]        flag_wdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_f,
  output logic [3:0]        out_nzcv,
  output logic [3:0]        flags
);

  localparam int          LW = $clog2(DATA_W);
  localparam logic [7:0]  WN = 8'(DATA_W);

  localparam logic [1:0] SH_LSL = 2'b00;
  localparam logic [1:0] SH_LSR = 2'b01;
  localparam logic [1:0] SH_ASR = 2'b10;

  localparam logic [3:0] OP_AND = 4'h0, OP_EOR = 4'h1, OP_SUB = 4'h2, OP_RSB = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4, OP_ADC = 4'h5, OP_SBC = 4'h6, OP_RSC = 4'h7;
  localparam logic [3:0] OP_TST = 4'h8, OP_TEQ = 4'h9, OP_CMP = 4'hA, OP_CMN = 4'hB;
  localparam logic [3:0] OP_ORR = 4'hC, OP_MOV = 4'hD, OP_BIC = 4'hE;

  // Barrel shifter. Returns {carry, result}. A shift amount of zero passes
  // the data and the incoming carry through. The exception is RRX when it
  // is enabled.
  function automatic logic [DATA_W:0] barrel(
    input logic [DATA_W-1:0] d,
    input logic [7:0]        n,
    input logic [1:0]        op,
    input logic              cin
  );
    logic [DATA_W-1:0]        r;
    logic                     c;
    logic [DATA_W:0]          ext;
    logic signed [DATA_W:0]   sext;
    logic [LW-1:0]            k;
    r    = d;
    c    = cin;
    ext  = '0;
    sext = '0;
    k    = n[LW-1:0];
    if (n != 8'd0) begin
      case (op)
        SH_LSL: begin
          if (n <= WN) begin
            // The extra top bit catches the last bit shifted out.
            ext = {1'b0, d} << n;
            r   = ext[DATA_W-1:0];
            c   = ext[DATA_W];
          end else begin
            r = '0;
            c = 1'b0;
          end
        end
        SH_LSR: begin
          if (n <= WN) begin
            ext = {d, 1'b0} >> n;
            r   = ext[DATA_W:1];
            c   = ext[0];
          end else begin
            r = '0;
            c = 1'b0;
          end
        end
        SH_ASR: begin
          if (n < WN) begin
            sext = $signed({d, 1'b0}) >>> n;
            r    = sext[DATA_W:1];
            c    = sext[0];
          end else begin
            r = {DATA_W{d[DATA_W-1]}};
            c = d[DATA_W-1];
          end
        end
        default: begin
          // Rotate by n mod W. A multiple of W leaves the data unchanged.
          r = (d >> k) | (d << (DATA_W - int'(k)));
          c = r[DATA_W-1];
        end
      endcase
    end
`ifdef ALU_SHIFT_PIPE_RRX_EN
    else if (op == 2'b11) begin
      r = {cin, d[DATA_W-1:1]};
      c = d[0];
    end
`endif
    return {c, r};
  endfunction

  // ALU. Returns {N, Z, C, V, result}. The adder paths use a W+1-bit sum,
  // so the top bit is the carry. For subtraction that carry is NOT borrow.
  function automatic logic [DATA_W+3:0] alu(
    input logic [DATA_W-1:0] a,
    input logic [DATA_W-1:0] b,
    input logic [3:0]        op,
    input logic              shc,
    input logic              fl_c,
    input logic              fl_v
  );
    logic [DATA_W-1:0] f;
    logic [DATA_W-1:0] x;
    logic [DATA_W-1:0] y;
    logic [DATA_W:0]   sum;
    logic              ci;
    logic              arith;
    logic              c;
    logic              v;
    f     = '0;
    x     = a;
    y     = b;
    ci    = 1'b0;
    arith = 1'b0;
    c     = shc;
    v     = fl_v;
    case (op)
      OP_AND, OP_TST: f = a & b;
      OP_EOR, OP_TEQ: f = a ^ b;
      OP_ORR:         f = a | b;
      OP_MOV:         f = b;
      OP_BIC:         f = a & ~b;
      OP_SUB, OP_CMP: begin x = a; y = ~b; ci = 1'b1; arith = 1'b1; end
      OP_RSB:         begin x = b; y = ~a; ci = 1'b1; arith = 1'b1; end
      OP_ADD, OP_CMN: begin x = a; y = b;  ci = 1'b0; arith = 1'b1; end
      OP_ADC:         begin x = a; y = b;  ci = fl_c; arith = 1'b1; end
      OP_SBC:         begin x = a; y = ~b; ci = fl_c; arith = 1'b1; end
      OP_RSC:         begin x = b; y = ~a; ci = fl_c; arith = 1'b1; end
      default:        f = ~b;
    endcase
    sum = {1'b0, x} + {1'b0, y} + {{DATA_W{1'b0}}, ci};
    if (arith) begin
      f = sum[DATA_W-1:0];
      c = sum[DATA_W];
      v = (x[DATA_W-1] == y[DATA_W-1]) && (f[DATA_W-1] != x[DATA_W-1]);
    end
    return {f[DATA_W-1], (f == '0), c, v, f};
  endfunction

  logic              en;
  logic              vld_p1_q;
  logic [DATA_W-1:0] a_p1_q;
  logic [DATA_W-1:0] d_p1_q;
  logic [7:0]        n_p1_q;
  logic [1:0]        sop_p1_q;
  logic [3:0]        op_p1_q;
  logic              s_p1_q;

  logic [DATA_W:0]   sh_p2;
  logic [DATA_W+3:0] res_p2;
  logic [DATA_W-1:0] f_p2_d;
  logic [3:0]        nzcv_p2_d;
  logic              vld_p2_q;
  logic [DATA_W-1:0] f_p2_q;
  logic [3:0]        nzcv_p2_q;
  logic              flag_upd;
  logic [3:0]        flags_d;
  logic [3:0]        flags_q;

  // Both stages advance together whenever the output slot is free or being drained.
  assign en       = !vld_p2_q || out_ready;
  assign in_ready = en;

  // ---- Stage 1: operand capture ----
  // Capture the valid bit. This is control, so it is reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1_q <= 1'b0;
    end else if (en) begin
      vld_p1_q <= in_valid;
    end
  end

  // Capture the operand fields. This is data, so it is not reset.
  always_ff @(posedge clk) begin
    if (en) begin
      a_p1_q   <= in_a;
      d_p1_q   <= in_shift_data;
      n_p1_q   <= in_shift_num;
      sop_p1_q <= in_shift_op;
      op_p1_q  <= in_alu_op;
      s_p1_q   <= in_s;
    end
  end

  // ---- Stage 2: shift + ALU against the current flag register ----
  // Shift operand B, then run the ALU using the flags registered at the start of the cycle.
  always_comb begin
    sh_p2     = barrel(d_p1_q, n_p1_q, sop_p1_q, flags_q[1]);
    res_p2    = alu(a_p1_q, sh_p2[DATA_W-1:0], op_p1_q, sh_p2[DATA_W], flags_q[1], flags_q[0]);
    f_p2_d    = res_p2[DATA_W-1:0];
    nzcv_p2_d = res_p2[DATA_W+3:DATA_W];
  end

  // Register the result slot. Reset clears the result along with the valid bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2_q  <= 1'b0;
      f_p2_q    <= '0;
      nzcv_p2_q <= '0;
    end else if (en) begin
      vld_p2_q  <= vld_p1_q;
      f_p2_q    <= f_p2_d;
      nzcv_p2_q <= nzcv_p2_d;
    end
  end

  // Select the next flag value. An external load overrides an ALU writeback in the same cycle.
  always_comb begin
    flag_upd = en && vld_p1_q && (s_p1_q || (op_p1_q[3:2] == 2'b10));
    flags_d  = flags_q;
    if (flag_wr) begin
      flags_d = flag_wdata;
    end else if (flag_upd) begin
      flags_d = nzcv_p2_d;
    end
  end

  // Hold the architectural flag register.
  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q <= 4'b0000;
    end else begin
      flags_q <= flags_d;
    end
  end

  assign out_valid = vld_p2_q;
  assign out_f     = f_p2_q;
  assign out_nzcv  = nzcv_p2_q;
  assign flags     = flags_q;

endmodule

// File: tb/tb_alu_shift_pipe.sv
// Self-checking bench for alu_shift_pipe (DATA_W = 32). A table of single
// operations drives a scoreboard. Hand-written sequences cover back-to-back
// flag use, stalls, flag_wr collisions and reset with operations in flight.
module tb_alu_shift_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a;
  logic [31:0] in_shift_data;
  logic [7:0]  in_shift_num;
  logic [1:0]  in_shift_op;
  logic [3:0]  in_alu_op;
  logic        in_s;
  logic        flag_wr;
  logic [3:0]  flag_wdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_f;
  logic [3:0]  out_nzcv;
  logic [3:0]  flags;

  alu_shift_pipe #(.DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_shift_data(in_shift_data), .in_shift_num(in_shift_num),
    .in_shift_op(in_shift_op), .in_alu_op(in_alu_op), .in_s(in_s),
    .flag_wr(flag_wr), .flag_wdata(flag_wdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_f(out_f), .out_nzcv(out_nzcv), .flags(flags)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] f;
    logic [3:0]  n;
  } exp_t;

  typedef struct {
    logic [3:0]  fl;
    logic [31:0] a;
    logic [31:0] d;
    logic [7:0]  n;
    logic [1:0]  sop;
    logic [3:0]  op;
    logic        s;
    logic [31:0] ef;
    logic [3:0]  en;
  } vec_t;

  exp_t        exp_q[$];
  vec_t        vecs[$];
  logic [31:0] exp_cur_f;
  logic [3:0]  exp_cur_n;
  int          n_chk  = 0;
  int          n_fail = 0;
  int          n_out  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  // Scoreboard: push on accepted input, pop and compare on accepted output.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      exp_q.delete();
    end else begin
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        n_out++;
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL sb_unexpected_output: got f=%h required no output", out_f);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("sb_f[%0d]", n_out), out_f, e.f);
          check($sformatf("sb_nzcv[%0d]", n_out), {28'd0, out_nzcv}, {28'd0, e.n});
        end
      end
      if (in_valid === 1'b1 && in_ready === 1'b1) begin
        exp_q.push_back({exp_cur_f, exp_cur_n});
      end
    end
  end

  task automatic add(input logic [3:0] fl, input logic [31:0] a, input logic [31:0] d,
                     input logic [7:0] n, input logic [1:0] sop, input logic [3:0] op,
                     input logic s, input logic [31:0] ef, input logic [3:0] en);
    vec_t v;
    v.fl = fl; v.a = a; v.d = d; v.n = n; v.sop = sop; v.op = op; v.s = s; v.ef = ef; v.en = en;
    vecs.push_back(v);
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [7:0] n,
                      input logic [1:0] sop, input logic [3:0] op, input logic s,
                      input logic [31:0] ef, input logic [3:0] en);
    bit acc;
    acc = 1'b0;
    in_valid = 1'b1; in_a = a; in_shift_data = d; in_shift_num = n;
    in_shift_op = sop; in_alu_op = op; in_s = s;
    exp_cur_f = ef; exp_cur_n = en;
    for (int t = 0; t < 50 && !acc; t++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!acc) begin
      n_chk++;
      n_fail++;
      $display("FAIL send_timeout: got in_ready=0 required 1 within 50 cycles");
    end
  endtask

  task automatic set_flags(input logic [3:0] v);
    flag_wr = 1'b1;
    flag_wdata = v;
    @(posedge clk);
    #1;
    flag_wr = 1'b0;
  endtask

  task automatic wait_out(input int target);
    for (int t = 0; t < 50; t++) begin
      if (n_out >= target) break;
      @(posedge clk);
      #1;
    end
    n_chk++;
    if (n_out < target) begin
      n_fail++;
      $display("FAIL wait_out_timeout: got %0d outputs required %0d", n_out, target);
    end
  endtask

  initial begin
    int base;
    logic [3:0] ef;
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_shift_data = '0; in_shift_num = '0;
    in_shift_op = '0; in_alu_op = '0; in_s = 1'b0; flag_wr = 1'b0; flag_wdata = '0;
    out_ready = 1'b1; exp_cur_f = '0; exp_cur_n = '0;

    // fl, a, d, n, sop, op, s, expected f, expected nzcv
    add(4'h0, 32'h7FFFFFFF, 32'h00000001, 8'd0,  2'd0, 4'h4, 1'b1, 32'h80000000, 4'h9);
    add(4'h0, 32'h0,        32'h80000001, 8'd32, 2'd0, 4'hD, 1'b1, 32'h00000000, 4'h6);
    add(4'h2, 32'h0,        32'h80000001, 8'd33, 2'd1, 4'hD, 1'b1, 32'h00000000, 4'h4);
    add(4'h0, 32'h0,        32'h80000001, 8'd32, 2'd1, 4'hD, 1'b1, 32'h00000000, 4'h6);
    add(4'h0, 32'h0,        32'h80000001, 8'd40, 2'd2, 4'hD, 1'b1, 32'hFFFFFFFF, 4'hA);
    add(4'h0, 32'h0,        32'h7FFFFFFF, 8'd32, 2'd2, 4'hD, 1'b1, 32'h00000000, 4'h4);
    add(4'h0, 32'h0,        32'h80000001, 8'd32, 2'd3, 4'hD, 1'b1, 32'h80000001, 4'hA);
    add(4'h3, 32'h0,        32'h00000005, 8'd0,  2'd0, 4'hD, 1'b1, 32'h00000005, 4'h3);
    add(4'h0, 32'h0,        32'hF000000F, 8'd4,  2'd0, 4'hD, 1'b1, 32'h000000F0, 4'h2);
    add(4'h0, 32'h0,        32'hF000000F, 8'd4,  2'd1, 4'hD, 1'b1, 32'h0F000000, 4'h2);
    add(4'h0, 32'h0,        32'h80000010, 8'd4,  2'd2, 4'hD, 1'b1, 32'hF8000001, 4'h8);
    add(4'h0, 32'h0,        32'h12345678, 8'd8,  2'd3, 4'hD, 1'b1, 32'h78123456, 4'h0);
    add(4'h0, 32'h0,        32'h12345678, 8'd36, 2'd3, 4'hD, 1'b1, 32'h81234567, 4'hA);
    add(4'h0, 32'h00000000, 32'h80000001, 8'd1,  2'd0, 4'h4, 1'b1, 32'h00000002, 4'h0);
    add(4'h0, 32'h00000003, 32'h00000005, 8'd0,  2'd0, 4'h2, 1'b1, 32'hFFFFFFFE, 4'h8);
    add(4'h0, 32'h00000003, 32'h00000005, 8'd0,  2'd0, 4'h3, 1'b1, 32'h00000002, 4'h2);
    add(4'h0, 32'h0000000A, 32'h00000003, 8'd0,  2'd0, 4'h6, 1'b1, 32'h00000006, 4'h2);
    add(4'h2, 32'h00000003, 32'h0000000A, 8'd0,  2'd0, 4'h7, 1'b1, 32'h00000007, 4'h2);
    add(4'h0, 32'hFFFFFFFF, 32'h00000001, 8'd0,  2'd0, 4'h4, 1'b1, 32'h00000000, 4'h6);
    add(4'h0, 32'h80000000, 32'h00000001, 8'd0,  2'd0, 4'h2, 1'b1, 32'h7FFFFFFF, 4'h3);
    add(4'h0, 32'h7FFFFFFF, 32'hFFFFFFFF, 8'd0,  2'd0, 4'h2, 1'b1, 32'h80000000, 4'h9);
    add(4'h0, 32'h000000F0, 32'h0000000F, 8'd0,  2'd0, 4'h8, 1'b0, 32'h00000000, 4'h4);
    add(4'h1, 32'h000000FF, 32'h000000FF, 8'd0,  2'd0, 4'h9, 1'b0, 32'h00000000, 4'h5);
    add(4'h0, 32'h00000003, 32'h00000005, 8'd0,  2'd0, 4'hA, 1'b0, 32'hFFFFFFFE, 4'h8);
    add(4'h0, 32'h00000001, 32'hFFFFFFFF, 8'd0,  2'd0, 4'hB, 1'b0, 32'h00000000, 4'h6);
    add(4'hF, 32'h000000F0, 32'h0000000F, 8'd0,  2'd0, 4'hC, 1'b0, 32'h000000FF, 4'h3);
    add(4'h0, 32'h000000FF, 32'h0000000F, 8'd0,  2'd0, 4'hE, 1'b1, 32'h000000F0, 4'h0);
    add(4'h0, 32'h00000000, 32'h00000000, 8'd0,  2'd0, 4'hF, 1'b1, 32'hFFFFFFFF, 4'h8);
    add(4'h0, 32'hFFFF0000, 32'h0F0F0F0F, 8'd0,  2'd0, 4'h0, 1'b1, 32'h0F0F0000, 4'h0);
    add(4'h0, 32'hFFFFFFFF, 32'h00000000, 8'd0,  2'd0, 4'h1, 1'b1, 32'hFFFFFFFF, 4'h8);
    add(4'h2, 32'h00000001, 32'h00000001, 8'd0,  2'd0, 4'h5, 1'b1, 32'h00000003, 4'h0);
`ifdef ALU_SHIFT_PIPE_RRX_EN
    add(4'h2, 32'h0,        32'h00000003, 8'd0,  2'd3, 4'hD, 1'b1, 32'h80000001, 4'hA);
`else
    add(4'h2, 32'h0,        32'h00000003, 8'd0,  2'd3, 4'hD, 1'b1, 32'h00000003, 4'h2);
`endif

    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_out_valid", {31'd0, out_valid}, 32'd0);
    check("reset_out_f", out_f, 32'd0);
    check("reset_out_nzcv", {28'd0, out_nzcv}, 32'd0);
    check("reset_flags", {28'd0, flags}, 32'd0);
    check("reset_in_ready", {31'd0, in_ready}, 32'd1);

    // Table of isolated operations, each starting from a preset flag value
    foreach (vecs[i]) begin
      set_flags(vecs[i].fl);
      base = n_out;
      send(vecs[i].a, vecs[i].d, vecs[i].n, vecs[i].sop, vecs[i].op, vecs[i].s, vecs[i].ef, vecs[i].en);
      wait_out(base + 1);
      ef = (vecs[i].s || (vecs[i].op >= 4'h8 && vecs[i].op <= 4'hB)) ? vecs[i].en : vecs[i].fl;
      check($sformatf("vec%0d_flags", i), {28'd0, flags}, {28'd0, ef});
    end

    // Back-to-back flag chain: CMP sets C=1, and ADC consumes it the next cycle
    set_flags(4'h0);
    base = n_out;
    send(32'd5, 32'd5, 8'd0, 2'd0, 4'hA, 1'b0, 32'h0, 4'h6);
    send(32'd1, 32'd1, 8'd0, 2'd0, 4'h5, 1'b1, 32'h3, 4'h0);
    wait_out(base + 2);
    check("chain_flags", {28'd0, flags}, 32'h0);

    // Back-pressure: three ops offered while the output is held
    set_flags(4'h0);
    base = n_out;
    out_ready = 1'b0;
    send(32'd1, 32'd1, 8'd0, 2'd0, 4'h4, 1'b0, 32'd2, 4'h0);
    send(32'd2, 32'd2, 8'd0, 2'd0, 4'h4, 1'b0, 32'd4, 4'h0);
    fork
      send(32'd3, 32'd3, 8'd0, 2'd0, 4'h4, 1'b0, 32'd6, 4'h0);
      begin
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          check($sformatf("stall%0d_in_ready", c), {31'd0, in_ready}, 32'd0);
          check($sformatf("stall%0d_out_valid", c), {31'd0, out_valid}, 32'd1);
          check($sformatf("stall%0d_out_f_hold", c), out_f, 32'd2);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    wait_out(base + 3);
    repeat (3) @(posedge clk);
    #1;
    check("bp_output_count", n_out, base + 3);
    check("bp_queue_empty", exp_q.size(), 32'd0);
    check("bp_drained", {31'd0, out_valid}, 32'd0);

    // flag_wr collides with a completing SUB S=1, and the external load wins
    set_flags(4'h0);
    base = n_out;
    send(32'd5, 32'd5, 8'd0, 2'd0, 4'h2, 1'b1, 32'h0, 4'h6);
    flag_wr = 1'b1;
    flag_wdata = 4'b0010;
    @(posedge clk);
    #1;
    flag_wr = 1'b0;
    check("flagwr_wins", {28'd0, flags}, 32'h2);
    send(32'd1, 32'd1, 8'd0, 2'd0, 4'h5, 1'b0, 32'd3, 4'h0);
    wait_out(base + 2);
    check("flagwr_after_adc", {28'd0, flags}, 32'h2);

    // Reset with two ops in flight: everything is dropped silently
    set_flags(4'hF);
    out_ready = 1'b0;
    send(32'd7, 32'd1, 8'd0, 2'd0, 4'h4, 1'b1, 32'd8, 4'h0);
    send(32'd9, 32'd1, 8'd0, 2'd0, 4'h4, 1'b1, 32'd10, 4'h0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    out_ready = 1'b1;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_out_f", out_f, 32'd0);
    check("midrst_out_nzcv", {28'd0, out_nzcv}, 32'd0);
    check("midrst_flags", {28'd0, flags}, 32'd0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    base = n_out;
    repeat (4) @(posedge clk);
    #1;
    check("midrst_no_stale_output", n_out, base);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
